// File: rtl/cog_vcap_pkg.sv
// Shared types and field positions for the cog video capture block.
// Config register layout, FSM states and the sample-period decode live here.
package cog_vcap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } vcap_state_e;

    localparam int CFG_TRIG_EN  = 31;
    localparam int CFG_RUN      = 30;
    localparam int CFG_MODE     = 28;
    localparam int CFG_TRIG_POL = 21;
    localparam int CFG_TRIG_LSB = 16;
    localparam int CFG_GRP_LSB  = 9;
    localparam int CFG_BIT_LSB  = 0;
    localparam int SCL_PCLK_LSB = 12;

    // A zero period field stands for the longest period, 256 clocks.
    function automatic logic [8:0] pclks_decode(input logic [7:0] p);
        return (p == 8'd0) ? 9'd256 : {1'b0, p};
    endfunction

    // Low sample pin is 8*group + bit; the high pin is the next bit within the same group.
    function automatic logic [4:0] lo_pin(input logic [1:0] grp, input logic [2:0] bidx);
        return {grp, bidx};
    endfunction

    function automatic logic [4:0] hi_pin(input logic [1:0] grp, input logic [2:0] bidx);
        return {grp, bidx + 3'd1};
    endfunction

endpackage

// File: rtl/cog_vcap_if.sv
// Cog-side bus of the video capture block: config strobes, pins and the word handshake.
// valid/take: valid is high while pixel_out holds an unconsumed word; take is sampled only
// when valid is high, and a word is consumed on any rising clk_cog edge with valid & take.
interface cog_vcap_if;
    import cog_vcap_pkg::*;

    logic        setvcfg;
    logic        setscl;
    logic [31:0] data;
    logic [31:0] pin_in;
    logic        take;
    logic [31:0] pixel_out;
    logic        valid;
    logic        ovf;
    vcap_state_e dbg_state;

    modport master (
        output setvcfg, setscl, data, pin_in, take,
        input  pixel_out, valid, ovf, dbg_state
    );

    modport slave (
        input  setvcfg, setscl, data, pin_in, take,
        output pixel_out, valid, ovf, dbg_state
    );

endinterface

// File: rtl/cog_vcap_sync.sv
// Pin synchronizer for the capture block plus edge detection on the selected trigger pin.
// The edge compares the newest synchronized sample with the one before it.
module cog_vcap_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pins,
    input  logic [4:0]  trig_idx,
    input  logic        trig_pol,
    output logic [31:0] pins_s,
    output logic        edge_pulse
);

    logic [31:0] stage [SYNC_STAGES];
    logic [31:0] prev;
    logic        cur_b;
    logic        prev_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
            prev <= '0;
        end else begin
            stage[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
            prev <= stage[SYNC_STAGES-1];
        end
    end

    assign pins_s     = stage[SYNC_STAGES-1];
    assign cur_b      = pins_s[trig_idx];
    assign prev_b     = prev[trig_idx];
    assign edge_pulse = trig_pol ? (cur_b & ~prev_b) : (~cur_b & prev_b);

endmodule

// File: rtl/cog_vcap.sv
// Cog video capture: samples one or two synchronized pins every PCLKS clocks, packs them
// LSB-first into 32-bit words and offers each finished word over valid/take.
module cog_vcap
    import cog_vcap_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk_cog,
    input  logic      ena,
    cog_vcap_if.slave bus
);

    logic [31:0] cfg;
    logic [31:0] scl;
    logic [31:0] shift;
    logic [31:0] shift_nxt;
    logic [31:0] pixel_r;
    logic [4:0]  bitcnt;
    logic [5:0]  bit_sum;
    logic [8:0]  cnt;
    logic [8:0]  cnt_nxt;
    logic [8:0]  pclks;
    logic        valid_r;
    logic        ovf_r;
    logic        tick;
    logic        done;
    logic        lo;
    logic        hi;
    logic [31:0] pins_s;
    logic        edge_pulse;
    vcap_state_e state;
    vcap_state_e state_nxt;

    wire run     = cfg[CFG_RUN];
    wire trig_en = cfg[CFG_TRIG_EN];
    wire mode2   = cfg[CFG_MODE];
    wire [1:0] grp  = cfg[CFG_GRP_LSB +: 2];
    wire [2:0] bidx = cfg[CFG_BIT_LSB +: 3];

    logic unused_cfg_bits;
    assign unused_cfg_bits = ^{cfg[29], cfg[27:22], cfg[15:11], cfg[8:3], scl[31:20], scl[11:0]};

    cog_vcap_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk_cog),
        .rst_n      (ena),
        .pins       (bus.pin_in),
        .trig_idx   (cfg[CFG_TRIG_LSB +: 5]),
        .trig_pol   (cfg[CFG_TRIG_POL]),
        .pins_s     (pins_s),
        .edge_pulse (edge_pulse)
    );

    assign pclks = pclks_decode(scl[SCL_PCLK_LSB +: 8]);
    assign lo    = pins_s[lo_pin(grp, bidx)];
    assign hi    = pins_s[hi_pin(grp, bidx)];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tick      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    if (trig_en) begin
                        state_nxt = ST_ARM;
                    end else begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = pclks;
                    end
                end
            end
            ST_ARM: begin
                if (!run) begin
                    state_nxt = ST_IDLE;
                end else if (edge_pulse) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = pclks;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == 9'd1) begin
                    tick    = 1'b1;
                    cnt_nxt = pclks;
                end else begin
                    cnt_nxt = cnt - 9'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A config write restarts the FSM from IDLE, which then re-evaluates the new cfg.
        if (bus.setvcfg) begin
            state_nxt = ST_IDLE;
            tick      = 1'b0;
        end
    end

    always_ff @(posedge clk_cog or negedge ena) begin
        if (!ena) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign shift_nxt = mode2 ? {hi, lo, shift[31:2]} : {lo, shift[31:1]};
    assign bit_sum   = {1'b0, bitcnt} + (mode2 ? 6'd2 : 6'd1);
    assign done      = tick & bit_sum[5];

    always_ff @(posedge clk_cog or negedge ena) begin
        if (!ena) begin
            cfg     <= '0;
            scl     <= '0;
            shift   <= '0;
            bitcnt  <= '0;
            pixel_r <= '0;
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            if (bus.setscl) begin
                scl <= bus.data;
            end
            if (bus.setvcfg) begin
                cfg     <= bus.data;
                shift   <= '0;
                bitcnt  <= '0;
                valid_r <= 1'b0;
                ovf_r   <= 1'b0;
            end else begin
                if (tick) begin
                    shift  <= shift_nxt;
                    bitcnt <= bit_sum[4:0];
                end
                // An unconsumed word is never overwritten; the new one is dropped instead.
                if (done) begin
                    if (!valid_r || bus.take) begin
                        pixel_r <= shift_nxt;
                        valid_r <= 1'b1;
                    end else begin
                        ovf_r <= 1'b1;
                    end
                end else if (bus.take && valid_r) begin
                    valid_r <= 1'b0;
                end
            end
        end
    end

    assign bus.pixel_out = pixel_r;
    assign bus.valid     = valid_r;
    assign bus.ovf       = ovf_r;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_cog_vcap.sv
// Bench for cog_vcap: a time-based capture model (absolute tick times, bit-indexed word
// assembly, delayed pin history) checked every cycle, plus directed literal expectations.
module tb_cog_vcap;
  import cog_vcap_pkg::*;

  localparam int N = 2;

  logic clk_cog = 1'b0;
  logic ena = 1'b1;
  cog_vcap_if bus();

  cog_vcap #(.SYNC_STAGES(N)) dut (
    .clk_cog (clk_cog),
    .ena     (ena),
    .bus     (bus.slave)
  );

  always #5 clk_cog = ~clk_cog;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_cfg, m_scl, m_pix, m_acc;
  int          m_nbits;
  logic        m_valid, m_ovf;
  int          m_phase;      // 0 idle, 1 waiting for trigger, 2 capturing
  longint      m_edge, m_tick_at;
  logic [31:0] pin_q[$];     // pin_q[0] = pins seen at the latest edge

  function automatic int pclks_of(input logic [31:0] s);
    logic [7:0] p;
    p = s[19:12];
    return (p == 8'd0) ? 256 : int'(p);
  endfunction

  task automatic model_reset();
    m_cfg = '0; m_scl = '0; m_pix = '0; m_acc = '0; m_nbits = 0;
    m_valid = 1'b0; m_ovf = 1'b0; m_phase = 0; m_edge = 0; m_tick_at = 0;
    pin_q.delete();
    for (int i = 0; i <= N; i++) pin_q.push_back('0);
  endtask

  task automatic model_step();
    logic [31:0] syn, prv, word;
    logic lo, hi, done;
    int g, b, p, ti;
    m_edge++;
    syn = pin_q[N-1];
    prv = pin_q[N];
    p = pclks_of(m_scl);
    done = 1'b0;
    word = '0;
    if (bus.setvcfg) begin
      m_cfg = bus.data; m_acc = '0; m_nbits = 0;
      m_valid = 1'b0; m_ovf = 1'b0; m_phase = 0;
    end else begin
      case (m_phase)
        0: if (m_cfg[30]) begin
             if (m_cfg[31]) m_phase = 1;
             else begin m_phase = 2; m_tick_at = m_edge + p; end
           end
        1: if (!m_cfg[30]) m_phase = 0;
           else begin
             ti = int'(m_cfg[20:16]);
             if ((m_cfg[21] && syn[ti] && !prv[ti]) || (!m_cfg[21] && !syn[ti] && prv[ti])) begin
               m_phase = 2; m_tick_at = m_edge + p;
             end
           end
        default: if (!m_cfg[30]) m_phase = 0;
           else if (m_edge == m_tick_at) begin
             g = int'(m_cfg[10:9]);
             b = int'(m_cfg[2:0]);
             lo = syn[8*g + b];
             hi = syn[8*g + ((b + 1) % 8)];
             m_acc[m_nbits] = lo;
             m_nbits++;
             if (m_cfg[28]) begin m_acc[m_nbits] = hi; m_nbits++; end
             if (m_nbits == 32) begin done = 1'b1; word = m_acc; m_acc = '0; m_nbits = 0; end
             m_tick_at = m_edge + p;
           end
      endcase
      if (done) begin
        if (!m_valid || bus.take) begin m_pix = word; m_valid = 1'b1; end
        else m_ovf = 1'b1;
      end else if (bus.take && m_valid) begin
        m_valid = 1'b0;
      end
    end
    if (bus.setscl) m_scl = bus.data;
    pin_q.push_front(bus.pin_in);
    void'(pin_q.pop_back());
  endtask

  always @(posedge clk_cog or negedge ena) begin
    if (!ena) model_reset();
    else model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_cog) begin
    if (ena) begin
      check32("pixel_out", bus.pixel_out, m_pix);
      check32("valid", 32'(bus.valid), 32'(m_valid));
      check32("ovf", 32'(bus.ovf), 32'(m_ovf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_scl(input logic [31:0] d);
    bus.setscl = 1'b1;
    bus.data = d;
    @(negedge clk_cog);
    bus.setscl = 1'b0;
  endtask

  task automatic test_1bpp();
    logic [31:0] pat;
    pat = 32'hA5A5_A5A5;
    write_scl(32'h0000_1000);
    for (int j = 0; j < 70; j++) begin
      bus.setvcfg = (j == 0);
      bus.data = 32'h4000_0003;
      bus.pin_in = $urandom;
      bus.pin_in[3] = pat[j % 32];
      bus.take = (j == 35);
      if (j == 33) check32("t1_valid_before", 32'(bus.valid), 32'd0);
      if (j == 34) check32("t1_valid_rise", 32'(bus.valid), 32'd1);
      if (j == 35) check32("t1_word1", bus.pixel_out, 32'hA5A5_A5A5);
      if (j == 67) begin
        check32("t1_word2", bus.pixel_out, 32'hA5A5_A5A5);
        check32("t1_valid2", 32'(bus.valid), 32'd1);
        check32("t1_no_ovf", 32'(bus.ovf), 32'd0);
      end
      @(negedge clk_cog);
    end
    bus.take = 1'b0;
  endtask

  task automatic test_2bpp();
    logic [31:0] w;
    int k;
    w = 32'h1B2B_3B4B;
    write_scl(32'h0000_4000);
    for (int j = 0; j < 71; j++) begin
      k = (j < 1) ? 0 : (j - 1) / 4;
      if (k > 15) k = 15;
      bus.setvcfg = (j == 0);
      bus.data = 32'h5000_0407;
      bus.pin_in = $urandom;
      bus.pin_in[23] = w[2*k];
      bus.pin_in[16] = w[2*k + 1];
      if (j == 65) check32("t2_valid_before", 32'(bus.valid), 32'd0);
      if (j == 66) check32("t2_valid_rise", 32'(bus.valid), 32'd1);
      if (j == 67) check32("t2_word", bus.pixel_out, w);
      @(negedge clk_cog);
    end
  endtask

  task automatic test_pclk256();
    int found;
    found = -1;
    write_scl(32'h0000_0000);
    for (int j = 0; j < 5000 && found < 0; j++) begin
      bus.setvcfg = (j == 0);
      bus.data = 32'h5000_0000;
      bus.pin_in = $urandom;
      if (j >= 1 && bus.valid) found = j;
      @(negedge clk_cog);
    end
    bus.setvcfg = 1'b0;
    check32("t3_256_latency", found, 32'd4098);
  endtask

  task automatic test_trigger();
    bus.pin_in = 32'h0000_0020;
    write_scl(32'h0000_3000);
    for (int j = 0; j < 150; j++) begin
      bus.setvcfg = (j == 0);
      bus.data = 32'hC025_0000;
      bus.take = ($urandom_range(0, 1) == 0);
      bus.pin_in = (j < 4) ? 32'h0000_0020 : $urandom;
      if (j >= 4 && j < 14) bus.pin_in[5] = 1'b0;
      if (j >= 14 && j < 21) bus.pin_in[5] = 1'b1;
      if (j == 13) check32("t4_fall_ignored", 32'(bus.dbg_state), 32'(ST_ARM));
      if (j == 16) check32("t4_still_armed", 32'(bus.dbg_state), 32'(ST_ARM));
      if (j == 17) check32("t4_started", 32'(bus.dbg_state), 32'(ST_RUN));
      @(negedge clk_cog);
    end
    bus.take = 1'b0;
  endtask

  task automatic test_handshake();
    logic [31:0] w1;
    w1 = '0;
    write_scl(32'h0000_1000);
    for (int j = 0; j < 101; j++) begin
      bus.setvcfg = (j == 0);
      bus.data = 32'h4000_0000;
      bus.pin_in = $urandom;
      bus.take = (j == 97);
      if (j == 40) begin
        w1 = m_pix;
        check32("t5_valid1", 32'(bus.valid), 32'd1);
        check32("t5_ovf_clear", 32'(bus.ovf), 32'd0);
      end
      if (j == 70) begin
        check32("t5_ovf_set", 32'(bus.ovf), 32'd1);
        check32("t5_hold_word1", bus.pixel_out, w1);
      end
      if (j == 98) begin
        check32("t5_valid_kept", 32'(bus.valid), 32'd1);
        check32("t5_word3", bus.pixel_out, m_pix);
      end
      @(negedge clk_cog);
    end
    bus.take = 1'b0;
    bus.setvcfg = 1'b1;
    bus.data = 32'h0000_0000;
    @(negedge clk_cog);
    bus.setvcfg = 1'b0;
    check32("t5_cfg_clr_valid", 32'(bus.valid), 32'd0);
    check32("t5_cfg_clr_ovf", 32'(bus.ovf), 32'd0);
  endtask

  task automatic test_ena();
    for (int j = 0; j < 40; j++) begin
      bus.setvcfg = (j == 0);
      bus.data = 32'h4000_0000;
      bus.pin_in = $urandom;
      @(negedge clk_cog);
    end
    check32("t6_valid_pre", 32'(bus.valid), 32'd1);
    #2 ena = 1'b0;
    #1;
    check32("t6_pix_zero", bus.pixel_out, 32'd0);
    check32("t6_valid_zero", 32'(bus.valid), 32'd0);
    check32("t6_ovf_zero", 32'(bus.ovf), 32'd0);
    check32("t6_state_idle", 32'(bus.dbg_state), 32'(ST_IDLE));
    @(negedge clk_cog);
    ena = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] d;
    int r;
    for (int c = 0; c < 4000; c++) begin
      bus.pin_in = $urandom;
      bus.take = ($urandom_range(0, 3) == 0);
      bus.setvcfg = 1'b0;
      bus.setscl = 1'b0;
      r = $urandom_range(0, 149);
      d = $urandom;
      if (r == 0) begin
        d[30] = ($urandom_range(0, 5) != 0);
        bus.setvcfg = 1'b1;
      end else if (r == 1 || r == 2) begin
        d[19:12] = 8'($urandom_range(0, 5));
        bus.setscl = 1'b1;
        bus.setvcfg = (r == 2);
      end
      bus.data = d;
      @(negedge clk_cog);
    end
    bus.setvcfg = 1'b0;
    bus.setscl = 1'b0;
    bus.take = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.setvcfg = 1'b0;
    bus.setscl = 1'b0;
    bus.data = '0;
    bus.pin_in = '0;
    bus.take = 1'b0;
    model_reset();
    #1 ena = 1'b0;
    repeat (3) @(negedge clk_cog);
    ena = 1'b1;
    @(negedge clk_cog);
    check32("rst_pixel", bus.pixel_out, 32'd0);
    check32("rst_valid", 32'(bus.valid), 32'd0);
    check32("rst_ovf", 32'(bus.ovf), 32'd0);
    check32("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    test_1bpp();
    test_2bpp();
    test_pclk256();
    test_trigger();
    test_handshake();
    test_ena();
    test_random();
    repeat (2) @(negedge clk_cog);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
